// File: rtl/load_pkg.sv
// rtl/load_pkg.sv - load-type codes, FSM states and lane constants for the load unit
package load_pkg;

  localparam logic [2:0] LW  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LHU = 3'd2;
  localparam logic [2:0] LB  = 3'd3;
  localparam logic [2:0] LBU = 3'd4;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RSP  = 2'd3
  } load_state_t;

  // True when the access does not sit on its natural boundary.
  function automatic logic is_misaligned(input logic [2:0] ld_type, input logic [1:0] addr_lo);
    logic w_mis;
    w_mis = 1'b0;
    if (ld_type == LW)
      w_mis = (addr_lo != 2'b00);
    else if (ld_type == LH || ld_type == LHU)
      w_mis = addr_lo[0];
    return w_mis;
  endfunction

endpackage

// File: rtl/load_unit_if.sv
// rtl/load_unit_if.sv - request, memory and response bundle of the load unit (exc_adel under LOAD_ADEL_EN)
interface load_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_type;
  logic [4:0]        req_rd;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic [4:0]        rsp_rd;
  logic              busy;
`ifdef LOAD_ADEL_EN
  logic              exc_adel;

  modport slave (
    input  req_valid, req_addr, req_type, req_rd, mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, mem_req, mem_addr, rsp_valid, rsp_data, rsp_rd, busy, exc_adel
  );
  modport master (
    output req_valid, req_addr, req_type, req_rd, mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, mem_req, mem_addr, rsp_valid, rsp_data, rsp_rd, busy, exc_adel
  );
`else
  modport slave (
    input  req_valid, req_addr, req_type, req_rd, mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, mem_req, mem_addr, rsp_valid, rsp_data, rsp_rd, busy
  );
  modport master (
    output req_valid, req_addr, req_type, req_rd, mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, mem_req, mem_addr, rsp_valid, rsp_data, rsp_rd, busy
  );
`endif
endinterface

// File: rtl/load_ext.sv
// rtl/load_ext.sv - little-endian lane select and sign/zero extension of a read word
module load_ext
  import load_pkg::*;
(
  input  logic [WORD_W-1:0] i_word,
  input  logic [1:0]        i_addr_lo,
  input  logic [2:0]        i_type,
  output logic [WORD_W-1:0] o_data
);

  logic [BYTE_W-1:0] w_byte;
  logic [HALF_W-1:0] w_half;

  always_comb begin
    w_byte = i_word[BYTE_W-1:0];
    case (i_addr_lo)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      2'd3: w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
  end

  // Halfword loads ignore addr[0] and word loads ignore addr[1:0]: misalignment truncates.
  always_comb begin
    o_data = '0;
    case (i_type)
      LW:      o_data = i_word;
      LH:      o_data = {{(WORD_W-HALF_W){w_half[HALF_W-1]}}, w_half};
      LHU:     o_data = {{(WORD_W-HALF_W){1'b0}}, w_half};
      LB:      o_data = {{(WORD_W-BYTE_W){w_byte[BYTE_W-1]}}, w_byte};
      LBU:     o_data = {{(WORD_W-BYTE_W){1'b0}}, w_byte};
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// rtl/load_unit.sv - data-memory load path: req/gnt read, lane extract, one-cycle result (LOAD_ADEL_EN adds misaligned-address exception)
module load_unit
  import load_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         reset,
  load_unit_if.slave   bus
);

  load_state_t       r_state;
  load_state_t       w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_type;
  logic [4:0]        r_rd;
  logic [DATA_W-1:0] r_rsp_data;
  logic [4:0]        r_rsp_rd;
  logic [DATA_W-1:0] w_ext_data;
  logic              w_req_ready;
  logic              w_mem_req;
  logic              w_rsp_valid;
  logic              w_busy;
  logic              w_accept;
  logic              w_misaligned;

  assign w_accept = (r_state == S_IDLE) && bus.req_valid;

`ifdef LOAD_ADEL_EN
  logic r_exc;
  assign w_misaligned = is_misaligned(bus.req_type, bus.req_addr[1:0]);
`else
  assign w_misaligned = 1'b0;
`endif

  load_ext u_ext (
    .i_word    (bus.mem_rdata),
    .i_addr_lo (r_addr[1:0]),
    .i_type    (r_type),
    .o_data    (w_ext_data)
  );

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_req_ready = 1'b0;
    w_mem_req   = 1'b0;
    w_rsp_valid = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_req_ready = 1'b1;
        w_busy      = 1'b0;
        if (bus.req_valid)
          w_next = w_misaligned ? S_RSP : S_REQ;
      end
      S_REQ: begin
        w_mem_req = 1'b1;
        if (bus.mem_gnt)
          w_next = S_WAIT;
      end
      S_WAIT: begin
        if (bus.mem_rvalid)
          w_next = S_RSP;
      end
      S_RSP: begin
        w_rsp_valid = 1'b1;
        w_next      = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr     <= '0;
      r_type     <= '0;
      r_rd       <= '0;
      r_rsp_data <= '0;
      r_rsp_rd   <= '0;
`ifdef LOAD_ADEL_EN
      r_exc      <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_addr <= bus.req_addr;
        r_type <= bus.req_type;
        r_rd   <= bus.req_rd;
      end
`ifdef LOAD_ADEL_EN
      // Faulting loads skip memory and answer straight from IDLE.
      if (w_accept && w_misaligned) begin
        r_rsp_data <= '0;
        r_rsp_rd   <= bus.req_rd;
        r_exc      <= 1'b1;
      end
`endif
      if (r_state == S_WAIT && bus.mem_rvalid) begin
        r_rsp_data <= w_ext_data;
        r_rsp_rd   <= r_rd;
`ifdef LOAD_ADEL_EN
        r_exc      <= 1'b0;
`endif
      end
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.mem_req   = w_mem_req;
  assign bus.mem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_rd    = r_rsp_rd;
  assign bus.busy      = w_busy;
`ifdef LOAD_ADEL_EN
  assign bus.exc_adel  = r_exc & w_rsp_valid;
`endif

endmodule

// File: tb/tb_load_unit.sv
// tb/tb_load_unit.sv - directed self-checking bench for load_unit (covers LOAD_ADEL_EN when defined)
module tb_load_unit;
  import load_pkg::*;

  logic clk;
  logic reset;
  int   n_total;
  int   n_pass;

  load_unit_if bus ();

  load_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    if (obs === exp_v)
      n_pass++;
    else
      $display("FAIL %s: observed %h expected %h", tag, obs, exp_v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [2:0] t, input logic [31:0] a, input logic [4:0] rd,
                         input logic [31:0] rdata, input int gd, input int rvd, input bit hold,
                         input logic [31:0] exp_d);
    int          cyc;
    logic [31:0] exp_a;
    exp_a         = {a[31:2], 2'b00};
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_type  = t;
    bus.req_rd    = rd;
    check("idle_ready", bus.req_ready, 1);
    step();
    cyc = 1;
    if (!hold) begin
      bus.req_valid = 1'b0;
      bus.req_addr  = 32'hDEAD_BEEF;
      bus.req_rd    = 5'd31;
    end
    for (int k = 0; k < gd; k++) begin
      check("stall_mem_req", bus.mem_req, 1);
      check("stall_mem_addr", bus.mem_addr, exp_a);
      check("stall_ready", bus.req_ready, 0);
      check("stall_busy", bus.busy, 1);
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h5555_AAAA;
      step();
      cyc++;
    end
    bus.mem_rvalid = 1'b0;
    check("req_mem_req", bus.mem_req, 1);
    check("req_mem_addr", bus.mem_addr, exp_a);
    bus.mem_gnt = 1'b1;
    step();
    cyc++;
    bus.mem_gnt = 1'b0;
    check("wait_mem_req", bus.mem_req, 0);
    for (int k = 0; k < rvd; k++) begin
      check("wait_no_rsp", bus.rsp_valid, 0);
      check("wait_ready", bus.req_ready, 0);
      step();
      cyc++;
    end
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = rdata;
    step();
    cyc++;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0BAD_F00D;
    check("rsp_valid", bus.rsp_valid, 1);
    check("rsp_latency", cyc, 3 + gd + rvd);
    check("rsp_data", bus.rsp_data, exp_d);
    check("rsp_rd", bus.rsp_rd, rd);
    check("rsp_ready", bus.req_ready, 0);
`ifdef LOAD_ADEL_EN
    check("rsp_exc_clear", bus.exc_adel, 0);
`endif
    step();
    check("rsp_pulse_end", bus.rsp_valid, 0);
    check("rsp_data_hold", bus.rsp_data, exp_d);
  endtask

  initial begin
    n_total        = 0;
    n_pass         = 0;
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_type   = '0;
    bus.req_rd     = '0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    step();
    step();
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_rsp_rd", bus.rsp_rd, 0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_busy", bus.busy, 0);
    reset = 1'b0;

    do_load(LW,  32'h0000_0100, 5'd5,  32'h8765_4321, 0, 0, 0, 32'h8765_4321);
    do_load(LB,  32'h0000_0103, 5'd6,  32'h80FF_7F01, 0, 0, 0, 32'hFFFF_FF80);
    do_load(LBU, 32'h0000_0103, 5'd7,  32'h80FF_7F01, 0, 0, 0, 32'h0000_0080);
    do_load(LB,  32'h0000_0101, 5'd8,  32'h80FF_7F01, 0, 0, 0, 32'h0000_007F);
    do_load(LB,  32'h0000_0102, 5'd9,  32'h80FF_7F01, 0, 0, 0, 32'hFFFF_FFFF);
    do_load(LH,  32'h0000_0202, 5'd10, 32'h8001_1234, 0, 0, 0, 32'hFFFF_8001);
    do_load(LHU, 32'h0000_0202, 5'd11, 32'h8001_1234, 0, 0, 0, 32'h0000_8001);
    do_load(LH,  32'h0000_0200, 5'd12, 32'h8001_1234, 0, 0, 0, 32'h0000_1234);
    do_load(3'd7, 32'h0000_0204, 5'd13, 32'hFFFF_FFFF, 0, 0, 0, 32'h0000_0000);

    // Stalled grant and response with the next request held throughout.
    do_load(LW,  32'h0000_0300, 5'd14, 32'hCAFE_F00D, 4, 3, 1, 32'hCAFE_F00D);
    do_load(LW,  32'h0000_0300, 5'd14, 32'h1357_9BDF, 0, 0, 0, 32'h1357_9BDF);

    // Reset in WAIT, then a stray read response.
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_0101;
    bus.req_type  = LB;
    bus.req_rd    = 5'd3;
    step();
    bus.req_valid = 1'b0;
    bus.mem_gnt   = 1'b1;
    step();
    bus.mem_gnt   = 1'b0;
    check("abort_busy", bus.busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_rsp_valid", bus.rsp_valid, 0);
    check("abort_rsp_data", bus.rsp_data, 0);
    check("abort_rsp_rd", bus.rsp_rd, 0);
    check("abort_mem_req", bus.mem_req, 0);
    check("abort_mem_addr", bus.mem_addr, 0);
    check("abort_busy_clr", bus.busy, 0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h80FF_7F01;
    step();
    bus.mem_rvalid = 1'b0;
    check("stray_rsp_valid", bus.rsp_valid, 0);
    check("stray_busy", bus.busy, 0);
    step();
    check("stray_rsp_valid2", bus.rsp_valid, 0);
    do_load(LB, 32'h0000_0101, 5'd3, 32'h80FF_7F01, 0, 0, 0, 32'h0000_007F);

`ifdef LOAD_ADEL_EN
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_0102;
    bus.req_type  = LW;
    bus.req_rd    = 5'd20;
    step();
    bus.req_valid = 1'b0;
    check("adel_rsp_valid", bus.rsp_valid, 1);
    check("adel_exc", bus.exc_adel, 1);
    check("adel_rsp_data", bus.rsp_data, 0);
    check("adel_mem_req", bus.mem_req, 0);
    check("adel_rsp_rd", bus.rsp_rd, 20);
    step();
    check("adel_pulse_end", bus.rsp_valid, 0);
    check("adel_exc_end", bus.exc_adel, 0);
    check("adel_mem_req2", bus.mem_req, 0);
    do_load(LH, 32'h0000_0202, 5'd21, 32'h8001_1234, 0, 0, 0, 32'hFFFF_8001);
`else
    do_load(LW, 32'h0000_0102, 5'd20, 32'h1122_3344, 0, 0, 0, 32'h1122_3344);
    do_load(LH, 32'h0000_0203, 5'd21, 32'h8001_1234, 0, 0, 0, 32'hFFFF_8001);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
